mdu: RTL and testbench

Multiply/divide unit in the EX stage, beside the ALU. It takes the same forwarded A/B operands and runs multi-cycle MULT/MULTU/DIV/DIVU, plus single-cycle MTHI/MTLO. It holds the architectural HI/LO registers, whose values feed the EX result mux for MFHI/MFLO. It raises `busy` so the hazard unit can stall dependent MD instructions.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_md_calc.sv | 54 +++++
 rtl/mdu.sv | 109 ++++++++++
 tb/tb_mdu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and op-class helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_md_calc.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU; divide by zero returns current HI/LO.
module md_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  // The single overflowing case -2^31 / -1 is pinned to quotient -2^31, remainder 0.
  function automatic logic [63:0] div_s(input logic signed [31:0] n, input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if ((n == 32'sh8000_0000) && (d == -32'sd1)) begin
      q = n;
      r = 32'sd0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
    return {n % d, n / d};
  endfunction

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [63:0] sprod;
  logic        [63:0] uprod;

  always_comb begin
    sa    = {{32{a[31]}}, a};
    sb    = {{32{b[31]}}, b};
    sprod = sa * sb;
    uprod = {32'd0, a} * {32'd0, b};
  end

  always_comb begin
    res = {hi, lo};
    case (op)
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_DIV:   if (b != 32'd0) res = div_s(a, b);
      MD_DIVU:  if (b != 32'd0) res = div_u(a, b);
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: IDLE/RUN FSM with latency counter, result latch and HI/LO registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = 16;

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [63:0]      calc;
  logic [63:0]      res_p0;
  logic             ld_res;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;

  md_calc u_calc (
    .op  (MDUOp),
    .a   (A),
    .b   (B),
    .hi  (HI),
    .lo  (LO),
    .res (calc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ST_RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start && md_is_mul(MDUOp)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_W'(MULT_CYCLES);
        end else if (start && md_is_div(MDUOp)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_W'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // start is only honoured in IDLE; anything issued during RUN is dropped.
  always_comb begin
    ld_res = 1'b0;
    commit = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_res = start && (md_is_mul(MDUOp) || md_is_div(MDUOp));
        wr_hi  = start && (MDUOp == MD_MTHI);
        wr_lo  = start && (MDUOp == MD_MTLO);
      end
      ST_RUN:  commit = (cnt == CNT_W'(1));
      default: ;
    endcase
  end

  // Result is captured at issue; HI/LO are written only at completion.
  always_ff @(posedge clk) begin
    if (ld_res) res_p0 <= calc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      HI <= res_p0[63:32];
      LO <= res_p0[31:0];
    end else begin
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops against an arithmetic HI/LO model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  MDUOp = 4'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  function automatic int op_latency(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // Architectural effect of one op, from plain 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      4'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        mlo = sq[31:0]; mhi = sr[31:0];
      end
      4'd4: if (b != 0) begin mlo = a / b; mhi = a % b; end
      4'd5: mhi = a;
      4'd6: mlo = a;
      default: ;
    endcase
  endtask

  task automatic check_hilo(input string name);
    checks++;
    if (HI !== mhi) begin errors++; $display("FAIL %s HI got %h want %h", name, HI, mhi); end
    checks++;
    if (LO !== mlo) begin errors++; $display("FAIL %s LO got %h want %h", name, LO, mlo); end
  endtask

  // Issue one op at the next edge, then track busy and check HI/LO afterwards.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n;
    int cyc;
    n = op_latency(op);
    A = a; B = b; MDUOp = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDUOp = 4'd0;
    model(op, a, b);
    if (n == 0) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", name, busy); end
    end else begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise got %b want 1", name, busy); end
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (cyc != n) begin errors++; $display("FAIL %s busy_len got %0d want %0d", name, cyc, n); end
    end
    check_hilo(name);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    check_hilo("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_hilo("reset_idle");
  endtask

  task automatic test_mult;
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_const got %h_%h want ffffffff_fffffffa", HI, LO);
    end
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++;
    if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_const got %h_%h want fffffffe_00000001", HI, LO);
    end
  endtask

  task automatic test_div;
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    checks++;
    if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_m7_2_const got %h_%h want ffffffff_fffffffd", HI, LO);
    end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks++;
    if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      errors++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", HI, LO);
    end
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, "divu_big");
  endtask

  task automatic test_div_zero;
    run_op(4'd5, 32'h11, 32'd0, "mthi_pre");
    run_op(4'd6, 32'h22, 32'd0, "mtlo_pre");
    run_op(4'd4, 32'd100, 32'd0, "divu_by0");
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      errors++; $display("FAIL divu_by0_const got %h_%h want 00000011_00000022", HI, LO);
    end
    run_op(4'd3, 32'hDEAD_BEEF, 32'd0, "div_by0");
  endtask

  task automatic test_mthi_mtlo;
    run_op(4'd5, 32'h1234_5678, 32'd0, "mthi");
    checks++;
    if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_const got %h want 12345678", HI); end
    run_op(4'd6, 32'hCAFE_0001, 32'd0, "mtlo");
    run_op(4'd9, 32'hAAAA_AAAA, 32'h5, "op9_none");
    run_op(4'd0, 32'hBBBB_BBBB, 32'h5, "op0_none");
  endtask

  task automatic test_start_during_run;
    logic [31:0] a, b;
    int cyc;
    a = $urandom; b = $urandom;
    A = a; B = b; MDUOp = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model(4'd1, a, b);
    @(posedge clk); #1;
    A = 32'h5; MDUOp = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDUOp = 4'd0;
    cyc = 2;
    while (busy === 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL ignore_start busy_len got %0d want 5", cyc); end
    check_hilo("ignore_start");
  endtask

  task automatic test_async_reset;
    run_op(4'd5, 32'hA5A5_0001, 32'd0, "pre_rst_hi");
    run_op(4'd6, 32'h5A5A_0002, 32'd0, "pre_rst_lo");
    A = 32'd1000; B = 32'd7; MDUOp = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDUOp = 4'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    mhi = 32'd0; mlo = 32'd0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_rst busy got %b want 0", busy); end
    check_hilo("async_rst");
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_hilo("rst_discard");
    run_op(4'd1, 32'd6, 32'd7, "post_rst_mult");
    checks++;
    if (LO !== 32'd42) begin errors++; $display("FAIL post_rst_42 got %0d want 42", LO); end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_mthi_mtlo;
    test_start_during_run;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
